ysyx_25030093_idu_queue: RTL
============================

// Module: ysyx_25030093_idu_queue
// PURPOSE
//  Buffered, parametrised decode stage between IFU and EXU. Accepts {pc, inst} through a
//  valid/ready handshake into a DEPTH-entry FIFO and decodes the head entry combinationally.
//  Presents decoded control, register indices and sign-extended immediate through a second
//  valid/ready handshake. Replaces the single-slot IDLE/Prepare/Occurrence decoder: full
//  throughput, flush support, illegal-instruction and ebreak flags instead of a DPI call.
// PARAMETERS
//  DEPTH  2   FIFO entries; power of two, >= 2
//  XLEN   32  pc and immediate width
//  NREG   32  architectural registers; 16 selects RV32E, where any reg index >= 16 is illegal
// PORTS
//  clock         in   1     system clock
//  reset         in   1     synchronous, active-high
//  flush         in   1     discard all queued entries (redirect)
//  in_valid      in   1     IFU offers {in_pc, in_inst}
//  in_ready      out  1     queue can accept (= !full)
//  in_pc         in   XLEN  pc of offered instruction
//  in_inst       in   32    raw instruction
//  out_valid     out  1     head entry decoded and available (= !empty)
//  out_ready     in   1     EXU consumes head
//  out_pc        out  XLEN  pc of head entry
//  rd/rs1/rs2    out  5     inst[11:7], inst[19:15], inst[24:20]
//  imm           out  XLEN  sign-extended imm; I/S/B/U/J per format; 0 for R-type
//  alu_op        out  4     0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and, 10 pass-B
//  src_a_sel     out  2     00 rs1, 01 pc, 10 zero
//  src_b_sel     out  2     00 rs2, 01 imm, 10 const 4
//  wen           out  1     writes rd (forced 0 when rd == 0)
//  mem_rd/mem_wr out  1     load / store
//  mem_size      out  2     00 byte, 01 half, 10 word
//  mem_unsigned  out  1     lbu/lhu
//  br_type       out  3     0 none, 1 beq, 2 bne, 3 blt, 4 bge, 5 bltu, 6 bgeu, 7 jal/jalr
//  csr_op        out  2     00 none, 01 csrrw, 10 csrrs, 11 csrrc
//  ecall/mret/ebreak out 1  system-instruction flags
//  illegal       out  1     opcode/funct not in RV32I+Zicsr subset, or reg index >= NREG
//  count         out  clog2(DEPTH)+1  occupancy, for debug/perf
// BEHAVIOUR
//  Reset: count=0, wr/rd pointers 0, in_ready=1, out_valid=0; decoded outputs are don't-care
//   while out_valid=0 but must not be X (storage is reset to 32'h00000013, nop).
//  Enqueue when in_valid&in_ready: entry written at wr_ptr, wr_ptr+1 (mod DEPTH).
//  Dequeue when out_valid&out_ready: rd_ptr+1 (mod DEPTH).
//  Latency: entry accepted at edge t is visible on out_* in cycle t+1; no combinational
//   in->out bypass. Throughput: 1 instruction/cycle with simultaneous enq+deq.
//  Simultaneous enq+deq: count unchanged. When full, in_ready=0, so an enqueue in the same
//   cycle as a dequeue is not taken; it is accepted next cycle.
//  Stability: while out_valid & !out_ready all out_* hold their values.
//  flush (priority over enq/deq): next edge count=0, pointers=0; an in_valid in the flush
//   cycle is dropped. in_ready stays !full during flush.
//  Illegal entries are still presented (out_valid=1, illegal=1, wen=0, mem_rd=mem_wr=0,
//   csr_op=0); EXU raises the exception.
//  ebreak = (inst == 32'h00100073); ecall = 32'h00000073; mret = 32'h30200073.
//  imm arithmetic: I = sext(inst[31:20]); S = sext({inst[31:25],inst[11:7]});
//   B = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); U = {inst[31:12],12'b0};
//   J = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); sext widens to XLEN.
//  lui: src_a=zero, src_b=imm, add. auipc: src_a=pc, src_b=imm. jal/jalr: src_a=pc, src_b=4.
//  reset mid-operation: all queued entries discarded, same state as after power-up reset.
// TESTING
//  1 reset; push addi x1,x0,5 (32'h00500093) pc=0x80000000 -> next cycle out_valid=1, rd=1,
//    imm=5, alu_op=0, src_b_sel=01, wen=1, illegal=0.
//  2 out_ready=0, push DEPTH insts -> count=DEPTH, in_ready=0; 3rd push held; drain in order
//    with out_pc 0x..00,0x..04; wrap pointers across 3*DEPTH pushes, order preserved.
//  3 continuous in_valid=out_ready=1 over 16 insts -> 1 retired/cycle, count stays 1.
//  4 sw x2,-4(x1) (32'hFE20AE23) -> mem_wr=1, mem_size=10, imm=32'hFFFFFFFC; beq imm -8.
//  5 count=2 then flush with in_valid=1 -> next cycle count=0, out_valid=0, new inst dropped.
//  6 NREG=16: add x17,x1,x2 -> illegal=1, wen=0; 32'h00100073 -> ebreak=1; 32'hFFFFFFFF -> illegal=1.

Source files
------------

// File: rtl/ysyx_25030093_idu_queue.sv
// Buffered decode stage between IFU and EXU.
// A DEPTH-entry FIFO holds {pc, inst}. The head entry is decoded combinationally.
// Decoded control, register indices and the immediate go out on a valid/ready handshake.
// Illegal instructions are still presented, with side effects masked off, so EXU can trap.
module ysyx_25030093_idu_queue #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32,
    parameter int NREG  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [31:0]              in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [4:0]               rd,
    output logic [4:0]               rs1,
    output logic [4:0]               rs2,
    output logic [XLEN-1:0]          imm,
    output logic [3:0]               alu_op,
    output logic [1:0]               src_a_sel,
    output logic [1:0]               src_b_sel,
    output logic                     wen,
    output logic                     mem_rd,
    output logic                     mem_wr,
    output logic [1:0]               mem_size,
    output logic                     mem_unsigned,
    output logic [2:0]               br_type,
    output logic [1:0]               csr_op,
    output logic                     ecall,
    output logic                     mret,
    output logic                     ebreak,
    output logic                     illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [31:0] INST_NOP    = 32'h00000013;
    localparam logic [31:0] INST_ECALL  = 32'h00000073;
    localparam logic [31:0] INST_EBREAK = 32'h00100073;
    localparam logic [31:0] INST_MRET   = 32'h30200073;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [1:0] SRC_A_RS1  = 2'b00;
    localparam logic [1:0] SRC_A_PC   = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [2:0] BR_JUMP = 3'd7;

    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [31:0]     inst_q [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            enq;
    logic            deq;

    // Register index outside the implemented register file (RV32E when NREG=16)
    function automatic logic reg_bad(input logic [4:0] r);
        return 32'(r) >= 32'(NREG);
    endfunction

    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    // Flush wins over both handshakes, so neither pointer moves in a flush cycle
    assign enq = in_valid & in_ready & ~flush;
    assign deq = out_valid & out_ready & ~flush;

    // Pointer and occupancy bookkeeping; flush and reset both empty the queue
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; reset fills with nop so the idle head never decodes to X
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= INST_NOP;
            end
        end else if (enq) begin
            pc_q[wr_ptr]   <= in_pc;
            inst_q[wr_ptr] <= in_inst;
        end
    end

    // Head entry fields
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    assign inst   = inst_q[rd_ptr];
    assign out_pc = pc_q[rd_ptr];
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

    logic signed [31:0] dec_imm;
    logic [3:0] dec_alu;
    logic [1:0] dec_a, dec_b, dec_msize, dec_csr;
    logic [2:0] dec_br;
    logic dec_wen, dec_mrd, dec_mwr, dec_muns, dec_ecall, dec_mret, dec_ebreak;
    logic bad, use_rd, use_rs1, use_rs2;

    // Opcode/funct decode of the head entry; bad flags encodings outside RV32I+Zicsr
    always_comb begin
        dec_imm = '0;       dec_alu = ALU_ADD;  dec_a = SRC_A_RS1;  dec_b = SRC_B_RS2;
        dec_msize = 2'b00;  dec_csr = 2'b00;    dec_br = 3'd0;
        dec_wen = 1'b0;     dec_mrd = 1'b0;     dec_mwr = 1'b0;     dec_muns = 1'b0;
        dec_ecall = 1'b0;   dec_mret = 1'b0;    dec_ebreak = 1'b0;
        bad = 1'b0;         use_rd = 1'b0;      use_rs1 = 1'b0;     use_rs2 = 1'b0;
        case (opcode)
            OPC_LUI: begin
                use_rd = 1'b1; dec_wen = 1'b1;
                dec_a = SRC_A_ZERO; dec_b = SRC_B_IMM; dec_imm = imm_u;
            end
            OPC_AUIPC: begin
                use_rd = 1'b1; dec_wen = 1'b1;
                dec_a = SRC_A_PC; dec_b = SRC_B_IMM; dec_imm = imm_u;
            end
            OPC_JAL: begin
                use_rd = 1'b1; dec_wen = 1'b1; dec_br = BR_JUMP;
                dec_a = SRC_A_PC; dec_b = SRC_B_FOUR; dec_imm = imm_j;
            end
            OPC_JALR: begin
                use_rd = 1'b1; use_rs1 = 1'b1; dec_wen = 1'b1; dec_br = BR_JUMP;
                dec_a = SRC_A_PC; dec_b = SRC_B_FOUR; dec_imm = imm_i;
                bad = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec_alu = ALU_SUB; dec_imm = imm_b;
                case (funct3)
                    3'b000:  dec_br = 3'd1;
                    3'b001:  dec_br = 3'd2;
                    3'b100:  dec_br = 3'd3;
                    3'b101:  dec_br = 3'd4;
                    3'b110:  dec_br = 3'd5;
                    3'b111:  dec_br = 3'd6;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                use_rd = 1'b1; use_rs1 = 1'b1; dec_wen = 1'b1; dec_mrd = 1'b1;
                dec_b = SRC_B_IMM; dec_imm = imm_i;
                dec_msize = funct3[1:0]; dec_muns = funct3[2];
                bad = (funct3[1:0] == 2'b11) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec_mwr = 1'b1;
                dec_b = SRC_B_IMM; dec_imm = imm_s; dec_msize = funct3[1:0];
                bad = funct3[2] || (funct3[1:0] == 2'b11);
            end
            OPC_OPIMM: begin
                use_rd = 1'b1; use_rs1 = 1'b1; dec_wen = 1'b1;
                dec_b = SRC_B_IMM; dec_imm = imm_i;
                case (funct3)
                    3'b000: dec_alu = ALU_ADD;
                    3'b010: dec_alu = ALU_SLT;
                    3'b011: dec_alu = ALU_SLTU;
                    3'b100: dec_alu = ALU_XOR;
                    3'b110: dec_alu = ALU_OR;
                    3'b111: dec_alu = ALU_AND;
                    3'b001: begin
                        dec_alu = ALU_SLL;
                        bad = (funct7 != 7'b0000000);
                    end
                    default: begin
                        dec_alu = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
                        bad = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    end
                endcase
            end
            OPC_OP: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; dec_wen = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: dec_alu = ALU_ADD;
                    10'b0100000_000: dec_alu = ALU_SUB;
                    10'b0000000_001: dec_alu = ALU_SLL;
                    10'b0000000_010: dec_alu = ALU_SLT;
                    10'b0000000_011: dec_alu = ALU_SLTU;
                    10'b0000000_100: dec_alu = ALU_XOR;
                    10'b0000000_101: dec_alu = ALU_SRL;
                    10'b0100000_101: dec_alu = ALU_SRA;
                    10'b0000000_110: dec_alu = ALU_OR;
                    10'b0000000_111: dec_alu = ALU_AND;
                    default:         bad = 1'b1;
                endcase
            end
            OPC_FENCE: begin
                bad = (funct3 != 3'b000);
            end
            OPC_SYSTEM: begin
                if (inst == INST_ECALL) begin
                    dec_ecall = 1'b1;
                end else if (inst == INST_EBREAK) begin
                    dec_ebreak = 1'b1;
                end else if (inst == INST_MRET) begin
                    dec_mret = 1'b1;
                end else if (funct3 == 3'b001 || funct3 == 3'b010 || funct3 == 3'b011) begin
                    // Register forms only: csr_op has no encoding for the uimm variants.
                    // funct3[1:0] maps directly onto csr_op.
                    use_rd = 1'b1; use_rs1 = 1'b1; dec_wen = 1'b1;
                    dec_csr = funct3[1:0]; dec_imm = imm_i;
                end else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase
    end

    // Only fields that are actually register indices are range-checked
    assign illegal = bad | (use_rd & reg_bad(rd)) | (use_rs1 & reg_bad(rs1)) | (use_rs2 & reg_bad(rs2));

    // Side effects are suppressed for illegal entries; datapath selects pass through
    assign imm          = XLEN'(dec_imm);
    assign alu_op       = dec_alu;
    assign src_a_sel    = dec_a;
    assign src_b_sel    = dec_b;
    assign wen          = dec_wen & ~illegal & (rd != 5'd0);
    assign mem_rd       = dec_mrd & ~illegal;
    assign mem_wr       = dec_mwr & ~illegal;
    assign mem_size     = dec_msize;
    assign mem_unsigned = dec_muns;
    assign br_type      = illegal ? 3'd0 : dec_br;
    assign csr_op       = illegal ? 2'b00 : dec_csr;
    assign ecall        = dec_ecall & ~illegal;
    assign mret         = dec_mret & ~illegal;
    assign ebreak       = dec_ebreak & ~illegal;

endmodule
